// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial sequence detector with don't-care mask and saturating match counter
module seq_det_prog #(
    parameter int              LEN     = 4,
    parameter int              CNT_W   = 8,
    parameter bit              OVERLAP = 1'b1,
    parameter logic [LEN-1:0]  PAT_RST = 4'b1011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             cfg_wr,
    input  logic [LEN-1:0]   cfg_pat,
    input  logic [LEN-1:0]   cfg_mask,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(LEN);

    logic [LEN-1:0]   hist_q, hist_d, pat_q, pat_d, mask_q, mask_d, hist_sh;
    logic [FW-1:0]    fill_q, fill_d, fill_inc;
    logic             ovl_q, ovl_d, z_q, z_d, sat_q, sat_d, hit;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift/compare on samples, config load overrides sampling, counter saturates
    always_comb begin
        hist_sh  = {hist_q[LEN-2:0], x};
        fill_inc = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        hit      = en && !cfg_wr && (fill_inc == FULL) && (((hist_sh ^ pat_q) & mask_q) == '0);
        pat_d    = cfg_wr ? cfg_pat : pat_q;
        mask_d   = cfg_wr ? cfg_mask : mask_q;
        ovl_d    = cfg_wr ? cfg_ovl : ovl_q;
        hist_d   = cfg_wr ? '0 : (en ? hist_sh : hist_q);
        fill_d   = cfg_wr ? '0 : (!en ? fill_q : ((hit && !ovl_q) ? '0 : fill_inc));
        z_d      = hit;
        cnt_d    = cnt_clr ? '0 : ((hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q);
        sat_d    = !cnt_clr && (sat_q || (&cnt_d));
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_RST;
            mask_q <= '1;
            ovl_q  <= OVERLAP;
            z_q    <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            mask_q <= mask_d;
            ovl_q  <= ovl_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
endmodule
